// File: rtl/rsa_ahb_loader.sv
// AHB-Lite master that streams operands into the RSA modexp slave, runs it,
// and streams the result window back out. One non-pipelined transfer at a time.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// IDLE        | waiting for cmd_start
// WR_MODE     | write latched mode word to MODE
// WR_MODN     | NWORDS modulus words from the source stream to MODN
// WR_NP       | one nprime0 word from the source stream to NP
// WR_PCAL     | kick parameter calculation
// POLL        | read BUSY until bit0 clears (timeout guarded)
// WR_E        | NWORDS exponent words to E
// WR_MSG      | NWORDS message words to MSG
// WR_START    | kick the exponentiation
// WAIT_INTR   | wait for rsa_intr (timeout guarded)
// RD_RES      | read result window, one word per result handshake
// WR_CLR      | clear the slave interrupt
// DONE        | one-cycle completion pulse
module rsa_ahb_loader #(
   parameter int          NWORDS   = 32,
   parameter logic [31:0] RSA_BASE = 32'h2002_0000,
   parameter int          TIMEOUT  = 65535
) (
   input  logic        hclk,
   input  logic        hrst_b,
   input  logic        cmd_start,
   input  logic [4:0]  cmd_mode,
   input  logic        src_valid,
   input  logic [31:0] src_data,
   output logic        src_ready,
   output logic        res_valid,
   output logic [31:0] res_data,
   input  logic        res_ready,
   output logic [31:0] m_haddr,
   output logic [1:0]  m_htrans,
   output logic        m_hwrite,
   output logic [2:0]  m_hsize,
   output logic [31:0] m_hwdata,
   input  logic [31:0] m_hrdata,
   input  logic        m_hready,
   input  logic [1:0]  m_hresp,
   input  logic        rsa_intr,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [3:0] {
      S_IDLE, S_WR_MODE, S_WR_MODN, S_WR_NP, S_WR_PCAL, S_POLL, S_WR_E,
      S_WR_MSG, S_WR_START, S_WAIT_INTR, S_RD_RES, S_WR_CLR, S_DONE
   } state_t;

   typedef enum logic [1:0] {B_FREE, B_ADDR, B_DATA} bus_t;

   localparam int             TW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]  TMO_LOAD = TW'(TIMEOUT - 1);
   localparam logic [5:0]     LAST     = 6'(NWORDS - 1);
   localparam logic [1:0]     HT_IDLE  = 2'b00;
   localparam logic [1:0]     HT_NSEQ  = 2'b10;

   state_t         state;
   bus_t           bus;
   logic [5:0]     cnt;
   logic [TW-1:0]  tmo;
   logic [4:0]     mode_q;
   logic           resp_err;

   logic           operand_st;
   logic           xfer_st;
   logic           can_issue;
   logic           xfer_done;
   logic           xfer_bad;
   logic           xfer_ok;
   logic [11:0]    off_nxt;
   logic           wr_nxt;
   logic [31:0]    wdata_nxt;

   assign operand_st = (state == S_WR_MODN) || (state == S_WR_NP) ||
                       (state == S_WR_E)    || (state == S_WR_MSG);
   assign xfer_st    = operand_st || (state == S_WR_MODE) || (state == S_WR_PCAL) ||
                       (state == S_POLL) || (state == S_WR_START) ||
                       (state == S_RD_RES) || (state == S_WR_CLR);
   assign src_ready  = operand_st && (bus == B_FREE);

   // A pending result word blocks both the next result read and the final CLR.
   assign can_issue  = xfer_st && (bus == B_FREE) &&
                       (operand_st ? src_valid :
                        ((state == S_RD_RES) || (state == S_WR_CLR)) ? !res_valid : 1'b1);
   assign xfer_done  = (bus == B_DATA) && m_hready;
   assign xfer_bad   = xfer_done && ((m_hresp == 2'b01) || resp_err);
   assign xfer_ok    = xfer_done && !xfer_bad;

   assign m_hsize    = 3'b010;
   assign busy       = (state != S_IDLE);
   assign done       = (state == S_DONE);

   always_comb begin
      off_nxt   = 12'h000;
      wr_nxt    = 1'b1;
      wdata_nxt = 32'h0;
      case (state)
         S_WR_MODE:  begin off_nxt = 12'h020; wdata_nxt = {27'b0, mode_q}; end
         S_WR_MODN:  begin off_nxt = 12'h004; wdata_nxt = src_data; end
         S_WR_NP:    begin off_nxt = 12'h00C; wdata_nxt = src_data; end
         S_WR_PCAL:  off_nxt = 12'h014;
         S_POLL:     begin off_nxt = 12'h024; wr_nxt = 1'b0; end
         S_WR_E:     begin off_nxt = 12'h008; wdata_nxt = src_data; end
         S_WR_MSG:   begin off_nxt = 12'h000; wdata_nxt = src_data; end
         S_WR_START: off_nxt = 12'h010;
         S_RD_RES:   begin off_nxt = 12'hC00 + {4'b0, cnt, 2'b00}; wr_nxt = 1'b0; end
         S_WR_CLR:   off_nxt = 12'h01C;
         default:    off_nxt = 12'h000;
      endcase
   end

   always_ff @(posedge hclk or negedge hrst_b) begin
      if (!hrst_b) begin
         state     <= S_IDLE;
         bus       <= B_FREE;
         cnt       <= 6'd0;
         tmo       <= '0;
         mode_q    <= 5'd0;
         resp_err  <= 1'b0;
         m_htrans  <= HT_IDLE;
         m_haddr   <= 32'h0;
         m_hwrite  <= 1'b0;
         m_hwdata  <= 32'h0;
         res_valid <= 1'b0;
         res_data  <= 32'h0;
         err       <= 1'b0;
      end else begin
         if (res_valid && res_ready)
            res_valid <= 1'b0;

         if (can_issue) begin
            bus      <= B_ADDR;
            m_htrans <= HT_NSEQ;
            m_haddr  <= RSA_BASE + {20'b0, off_nxt};
            m_hwrite <= wr_nxt;
            m_hwdata <= wdata_nxt;
         end else if (bus == B_ADDR) begin
            bus      <= B_DATA;
            m_htrans <= HT_IDLE;
         end else if (bus == B_DATA) begin
            if (m_hready) begin
               bus      <= B_FREE;
               resp_err <= 1'b0;
            end else if (m_hresp == 2'b01) begin
               resp_err <= 1'b1;
            end
         end

         case (state)
            S_IDLE:
               if (cmd_start) begin
                  state  <= S_WR_MODE;
                  mode_q <= cmd_mode;
                  err    <= 1'b0;
               end
            S_WR_MODE:
               if (xfer_ok) begin state <= S_WR_MODN; cnt <= 6'd0; end
            S_WR_MODN:
               if (xfer_ok) begin
                  if (cnt == LAST) begin state <= S_WR_NP; cnt <= 6'd0; end
                  else cnt <= cnt + 6'd1;
               end
            S_WR_NP:
               if (xfer_ok) state <= S_WR_PCAL;
            S_WR_PCAL:
               if (xfer_ok) begin state <= S_POLL; tmo <= TMO_LOAD; end
            S_POLL:
               if (xfer_ok && !m_hrdata[0]) begin
                  state <= S_WR_E;
                  cnt   <= 6'd0;
               end else if (tmo == '0) begin
                  state    <= S_IDLE;
                  err      <= 1'b1;
                  bus      <= B_FREE;
                  m_htrans <= HT_IDLE;
                  resp_err <= 1'b0;
               end else begin
                  tmo <= tmo - 1'b1;
               end
            S_WR_E:
               if (xfer_ok) begin
                  if (cnt == LAST) begin state <= S_WR_MSG; cnt <= 6'd0; end
                  else cnt <= cnt + 6'd1;
               end
            S_WR_MSG:
               if (xfer_ok) begin
                  if (cnt == LAST) begin state <= S_WR_START; cnt <= 6'd0; end
                  else cnt <= cnt + 6'd1;
               end
            S_WR_START:
               if (xfer_ok) begin state <= S_WAIT_INTR; tmo <= TMO_LOAD; end
            S_WAIT_INTR:
               if (rsa_intr) begin
                  state <= S_RD_RES;
                  cnt   <= 6'd0;
               end else if (tmo == '0) begin
                  state <= S_IDLE;
                  err   <= 1'b1;
               end else begin
                  tmo <= tmo - 1'b1;
               end
            S_RD_RES:
               if (xfer_ok) begin
                  res_data  <= m_hrdata;
                  res_valid <= 1'b1;
                  if (cnt == LAST) begin state <= S_WR_CLR; cnt <= 6'd0; end
                  else cnt <= cnt + 6'd1;
               end
            S_WR_CLR:
               if (xfer_ok) state <= S_DONE;
            S_DONE:
               state <= S_IDLE;
            default:
               state <= S_IDLE;
         endcase

         // A bus error in any data phase abandons the run without further transfers.
         if (xfer_bad) begin
            state <= S_IDLE;
            err   <= 1'b1;
         end
      end
   end

endmodule
